// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential ALU.
//   alu_op_e    - 3-bit operation codes
//   alu_state_e - control FSM states
//   DefaultPoly - AES reduction polynomial (x^8 implicit)
package alu_pkg;

  typedef enum logic [2:0] {
    OpAnd   = 3'b000,
    OpOr    = 3'b001,
    OpXor   = 3'b010,
    OpAdd   = 3'b011,
    OpSub   = 3'b100,
    OpRotl  = 3'b101,
    OpGfmul = 3'b110,
    OpXtime = 3'b111
  } alu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMul  = 1'b1
  } alu_state_e;

  localparam logic [7:0] DefaultPoly = 8'h1B;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand and result handshake bundle for alu_seq.
//   in_valid/in_ready               - operand handshake (source -> ALU)
//   operand_a/operand_b/alu_op      - operands and operation code
//   out_valid/out_ready             - result handshake (ALU -> consumer)
//   result/zero/carry               - registered result and flags
// master: the round controller side; slave: the ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  alu_op_e          alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;

  modport master (
    output in_valid, operand_a, operand_b, alu_op, out_ready,
    input  in_ready, out_valid, result, zero, carry
  );

  modport slave (
    input  in_valid, operand_a, operand_b, alu_op, out_ready,
    output in_ready, out_valid, result, zero, carry
  );

endinterface

// File: rtl/alu_seq_gf_xtime.sv
// gf_xtime: multiply by x in GF(2^WIDTH), reducing by POLY (x^WIDTH implicit).
//   i_a - field element in
//   o_y - i_a * x mod POLY
module gf_xtime
  import alu_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DefaultPoly)
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = {i_a[WIDTH-2:0], 1'b0} ^ (i_a[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered result/flags behind a valid/ready output.
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   io_bus - alu_seq_if.slave: operand handshake in, result handshake out
// Single-cycle ops land in the output register on the accepting edge. GFMUL
// latches its operands and iterates MSB-first over b for WIDTH cycles, sharing
// the one gf_xtime instance with the XTIME op.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DefaultPoly)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  alu_seq_if.slave   io_bus
);

  localparam int unsigned      CntW     = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]  CntInit  = CntW'(WIDTH);
  localparam logic [WIDTH-1:0] WidthMod = WIDTH'(WIDTH);

  alu_state_e       r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [WIDTH-1:0] r_acc, w_acc_d;
  logic [WIDTH-1:0] r_result, w_result_d;
  logic             r_zero, w_zero_d;
  logic             r_carry, w_carry_d;
  logic             r_out_valid, w_out_valid_d;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_drain;
  alu_op_e          w_op;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_amt;
  logic [WIDTH-1:0] w_single;
  logic             w_single_carry;

  logic [WIDTH-1:0] w_xt_in;
  logic [WIDTH-1:0] w_xt_out;
  logic [WIDTH-1:0] w_mul_step;

  assign w_op       = io_bus.alu_op;
  // Only accept when the output slot is free or being drained this very edge.
  assign w_in_ready = !i_rst && (r_state == StIdle) && (!r_out_valid || io_bus.out_ready);
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_drain    = r_out_valid && io_bus.out_ready;

  // Shared xtime: fed by the accumulator while multiplying, else by operand_a.
  assign w_xt_in = (r_state == StMul) ? r_acc : io_bus.operand_a;

  gf_xtime #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_xtime (
    .i_a (w_xt_in),
    .o_y (w_xt_out)
  );

  assign w_mul_step = w_xt_out ^ (r_b[WIDTH-1] ? r_a : '0);

  // Single-cycle datapath.
  always_comb begin
    w_sum          = {1'b0, io_bus.operand_a} + {1'b0, io_bus.operand_b};
    w_diff         = {1'b0, io_bus.operand_a} - {1'b0, io_bus.operand_b};
    w_amt          = io_bus.operand_b % WidthMod;
    w_single       = '0;
    w_single_carry = 1'b0;
    unique case (w_op)
      OpAnd:   w_single = io_bus.operand_a & io_bus.operand_b;
      OpOr:    w_single = io_bus.operand_a | io_bus.operand_b;
      OpXor:   w_single = io_bus.operand_a ^ io_bus.operand_b;
      OpAdd: begin
        w_single       = w_sum[WIDTH-1:0];
        w_single_carry = w_sum[WIDTH];
      end
      OpSub: begin
        // Extended-width MSB of a-b is the borrow.
        w_single       = w_diff[WIDTH-1:0];
        w_single_carry = w_diff[WIDTH];
      end
      // Right shift by WIDTH yields 0, so amt==0 needs no special case.
      OpRotl:  w_single = (io_bus.operand_a << w_amt) |
                          (io_bus.operand_a >> (WidthMod - w_amt));
      OpGfmul: w_single = '0;
      OpXtime: w_single = w_xt_out;
    endcase
  end

  // Next-state logic for the FSM and the output register.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_a_d         = r_a;
    w_b_d         = r_b;
    w_acc_d       = r_acc;
    w_result_d    = r_result;
    w_zero_d      = r_zero;
    w_carry_d     = r_carry;
    w_out_valid_d = r_out_valid;

    if (w_drain) begin
      w_out_valid_d = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_op == OpGfmul) begin
            w_state_d = StMul;
            w_a_d     = io_bus.operand_a;
            w_b_d     = io_bus.operand_b;
            w_acc_d   = '0;
            w_cnt_d   = CntInit;
          end else begin
            w_result_d    = w_single;
            w_zero_d      = (w_single == '0);
            w_carry_d     = w_single_carry;
            w_out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        w_acc_d = w_mul_step;
        w_b_d   = {r_b[WIDTH-2:0], 1'b0};
        w_cnt_d = r_cnt - CntW'(1);
        // Output slot is guaranteed empty here: it was free or drained at accept.
        if (r_cnt == CntW'(1)) begin
          w_state_d     = StIdle;
          w_cnt_d       = '0;
          w_result_d    = w_mul_step;
          w_zero_d      = (w_mul_step == '0);
          w_carry_d     = 1'b0;
          w_out_valid_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_a         <= w_a_d;
      r_b         <= w_b_d;
      r_acc       <= w_acc_d;
      r_result    <= w_result_d;
      r_zero      <= w_zero_d;
      r_carry     <= w_carry_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.result    = r_result;
  assign io_bus.zero      = r_zero;
  assign io_bus.carry     = r_carry;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH 8, POLY 0x1B).
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(
    .WIDTH (8),
    .POLY  (8'h1B)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic drive(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid  = 1'b1;
    bus.alu_op    = op;
    bus.operand_a = a;
    bus.operand_b = b;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op    = OpAnd;
    bus.operand_a = '0;
    bus.operand_b = '0;

    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_in_ready", bus.in_ready, 0);

    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    // AND, latency 1
    drive(OpAnd, 8'hF0, 8'h3C);
    #1;
    check("and_pre_valid", bus.out_valid, 0);
    step();
    check("and_valid", bus.out_valid, 1);
    check("and_result", bus.result, 8'h30);
    check("and_zero", bus.zero, 0);
    check("and_carry", bus.carry, 0);

    // Back-to-back single-cycle ops with out_ready high
    drive(OpAdd, 8'hFF, 8'h01);
    step();
    check("add_result", bus.result, 8'h00);
    check("add_zero", bus.zero, 1);
    check("add_carry", bus.carry, 1);
    check("add_valid", bus.out_valid, 1);

    drive(OpSub, 8'h05, 8'h07);
    step();
    check("sub_result", bus.result, 8'hFE);
    check("sub_carry", bus.carry, 1);
    check("sub_zero", bus.zero, 0);

    drive(OpRotl, 8'h81, 8'd9);
    step();
    check("rotl_result", bus.result, 8'h03);
    check("rotl_carry", bus.carry, 0);

    drive(OpXtime, 8'h80, 8'h00);
    step();
    check("xtime_result", bus.result, 8'h1B);

    drive(OpOr, 8'h00, 8'h00);
    step();
    check("or_zero_result", bus.result, 8'h00);
    check("or_zero_flag", bus.zero, 1);

    bus.in_valid = 1'b0;
    step();
    check("drained_valid", bus.out_valid, 0);

    // GFMUL 0x57 * 0x83 = 0xC1, result 8 edges after accept
    drive(OpGfmul, 8'h57, 8'h83);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("gf_busy_ready", bus.in_ready, 0);
      check("gf_busy_valid", bus.out_valid, 0);
      step();
    end
    check("gf_last_ready", bus.in_ready, 0);
    check("gf_last_valid", bus.out_valid, 0);
    step();
    check("gf_valid", bus.out_valid, 1);
    check("gf_result", bus.result, 8'hC1);
    check("gf_zero", bus.zero, 0);
    check("gf_carry", bus.carry, 0);
    check("gf_done_ready", bus.in_ready, 1);

    // XOR accepted on the drain cycle
    drive(OpXor, 8'h55, 8'h0F);
    step();
    check("b2b_xor_valid", bus.out_valid, 1);
    check("b2b_xor_result", bus.result, 8'h5A);

    // Backpressure after ADD 0x80 + 0x90 = 0x10 carry 1
    drive(OpAdd, 8'h80, 8'h90);
    step();
    bus.out_ready = 1'b0;
    drive(OpAnd, 8'h0F, 8'h0C);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_valid", bus.out_valid, 1);
      check("bp_result", bus.result, 8'h10);
      check("bp_carry", bus.carry, 1);
      check("bp_zero", bus.zero, 0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    step();
    check("bp_next_valid", bus.out_valid, 1);
    check("bp_next_result", bus.result, 8'h0C);
    check("bp_next_carry", bus.carry, 0);
    bus.in_valid = 1'b0;
    step();
    check("bp_drained", bus.out_valid, 0);

    // Reset on the 4th GFMUL iteration edge
    drive(OpGfmul, 8'h57, 8'h83);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("abort_rst_ready", bus.in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("abort_valid", bus.out_valid, 0);
    check("abort_ready", bus.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("abort_quiet", bus.out_valid, 0);
    end
    drive(OpAnd, 8'hAA, 8'h0F);
    step();
    bus.in_valid = 1'b0;
    check("post_abort_valid", bus.out_valid, 1);
    check("post_abort_result", bus.result, 8'h0A);
    check("post_abort_zero", bus.zero, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
